// File: rtl/dmux4_reg_if.sv
// dmux4_reg_if: data, select and valid signals of the registered 1-to-4 demux
//   in/in_valid/s0/s1 : source side (driven by master)
//   i0..i3/out_valid  : registered outputs (driven by slave)
interface dmux4_reg_if #(parameter int DATA_W = 1);
  logic [DATA_W-1:0] in, i0, i1, i2, i3;
  logic in_valid, s0, s1;
  logic [3:0] out_valid;
  modport master(output in, in_valid, s0, s1, input i0, i1, i2, i3, out_valid);
  modport slave(input in, in_valid, s0, s1, output i0, i1, i2, i3, out_valid);
endinterface

// File: rtl/dmux4_reg.sv
// dmux4_reg: registered 1-to-4 demultiplexer with one-hot per-output valid
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears all outputs
//   bus   : dmux4_reg_if slave (in, in_valid, s1:s0 -> i0..i3, out_valid)
//   DMUX4_REG_HOLD_EN : unwritten outputs keep their value instead of clearing
module dmux4_reg #(parameter int DATA_W = 1) (
  input logic clk,
  input logic rst_n,
  dmux4_reg_if.slave bus
);
  logic [3:0] hot;
  logic [3:0][DATA_W-1:0] q;
  always_comb hot = bus.in_valid ? 4'b0001 << {bus.s1, bus.s0} : 4'b0000;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q <= '0;
      bus.out_valid <= 4'b0000;
    end else begin
      bus.out_valid <= hot;
      for (int k = 0; k < 4; k++)
`ifdef DMUX4_REG_HOLD_EN
        if (hot[k]) q[k] <= bus.in;
`else
        q[k] <= hot[k] ? bus.in : '0;
`endif
    end
  assign bus.i0 = q[0];
  assign bus.i1 = q[1];
  assign bus.i2 = q[2];
  assign bus.i3 = q[3];
endmodule

// File: tb/tb_dmux4_reg.sv
// tb_dmux4_reg: scoreboard bench driving a DATA_W=1 and a DATA_W=8 instance in lockstep
module tb_dmux4_reg;
  typedef struct packed {
    logic [7:0] o0, o1, o2, o3;
    logic [3:0] ov;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int compared = 0;
  int mismatched = 0;
  exp_t q1[$], q8[$];
  exp_t m1 = '0, m8 = '0;
  exp_t e1, e8;
  dmux4_reg_if #(.DATA_W(1)) b1();
  dmux4_reg_if #(.DATA_W(8)) b8();
  dmux4_reg #(.DATA_W(1)) u1(.clk(clk), .rst_n(rst_n), .bus(b1));
  dmux4_reg #(.DATA_W(8)) u8(.clk(clk), .rst_n(rst_n), .bus(b8));
  always #5 clk = ~clk;
  always @(posedge clk)
    if ((b1.in_valid && $isunknown({b1.s1, b1.s0})) || (b8.in_valid && $isunknown({b8.s1, b8.s0})))
      $error("illegal X/Z select while in_valid");
  function automatic exp_t act1();
    return {8'(b1.i0), 8'(b1.i1), 8'(b1.i2), 8'(b1.i3), b1.out_valid};
  endfunction
  function automatic exp_t act8();
    return {b8.i0, b8.i1, b8.i2, b8.i3, b8.out_valid};
  endfunction
  function automatic exp_t nxt(exp_t p, logic v, logic [1:0] sel, logic [7:0] d);
    exp_t n;
`ifdef DMUX4_REG_HOLD_EN
    n = p;
`else
    n = '0;
`endif
    n.ov = 4'b0000;
    if (v) begin
      n.ov[sel] = 1'b1;
      case (sel)
        2'd0: n.o0 = d;
        2'd1: n.o1 = d;
        2'd2: n.o2 = d;
        default: n.o3 = d;
      endcase
    end
    return n;
  endfunction
  task automatic set_in(input logic v, input logic [1:0] sel, input logic [7:0] d);
    b1.in = d[0];
    b8.in = d;
    b1.in_valid = v;
    b8.in_valid = v;
    {b1.s1, b1.s0} = sel;
    {b8.s1, b8.s0} = sel;
  endtask
  task automatic drive(input logic v, input logic [1:0] sel, input logic [7:0] d);
    @(negedge clk);
    set_in(v, sel, d);
    m1 = nxt(m1, v, sel, {7'b0, d[0]});
    m8 = nxt(m8, v, sel, d);
    q1.push_back(m1);
    q8.push_back(m8);
    @(posedge clk);
    #1;
    e1 = q1.pop_front();
    e8 = q8.pop_front();
  endtask
  task automatic test_reset();
    set_in(1'b1, 2'd0, 8'hFF);
    #1;
    compared += 2;
    if (act1() !== '0) begin mismatched++; $display("FAIL reset_w1 got=%h want=0", act1()); end
    if (act8() !== '0) begin mismatched++; $display("FAIL reset_w8 got=%h want=0", act8()); end
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 2'd0, 8'hFF);
    compared++;
    if (act8() !== e8) begin mismatched++; $display("FAIL reset_pre got=%h want=%h", act8(), e8); end
    @(negedge clk);
    set_in(1'b1, 2'd1, 8'hFF);
    #1 rst_n = 1'b0;
    #1;
    compared += 2;
    if (act1() !== '0) begin mismatched++; $display("FAIL reset_async_w1 got=%h want=0", act1()); end
    if (act8() !== '0) begin mismatched++; $display("FAIL reset_async_w8 got=%h want=0", act8()); end
    @(posedge clk);
    #1;
    compared++;
    if (act8() !== '0) begin mismatched++; $display("FAIL reset_hold got=%h want=0", act8()); end
    m1 = '0;
    m8 = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_sweep();
    logic [3:0] ov_tab [4];
    ov_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'(k), 8'h01);
      compared += 3;
      if (act1() !== e1) begin mismatched++; $display("FAIL sweep_w1 sel=%0d got=%h want=%h", k, act1(), e1); end
      if (act8() !== e8) begin mismatched++; $display("FAIL sweep_w8 sel=%0d got=%h want=%h", k, act8(), e8); end
      if (b1.out_valid !== ov_tab[k]) begin mismatched++; $display("FAIL sweep_ov sel=%0d got=%b want=%b", k, b1.out_valid, ov_tab[k]); end
    end
  endtask
  task automatic test_idle();
    logic want_i3;
`ifdef DMUX4_REG_HOLD_EN
    want_i3 = 1'b1;
`else
    want_i3 = 1'b0;
`endif
    drive(1'b0, 2'd3, 8'h01);
    compared += 3;
    if (b1.out_valid !== 4'b0000) begin mismatched++; $display("FAIL idle_ov got=%b want=0000", b1.out_valid); end
    if (b1.i3 !== want_i3) begin mismatched++; $display("FAIL idle_i3 got=%b want=%b", b1.i3, want_i3); end
    if (act1() !== e1) begin mismatched++; $display("FAIL idle_w1 got=%h want=%h", act1(), e1); end
  endtask
  task automatic test_zero();
    drive(1'b1, 2'd2, 8'h00);
    compared += 3;
    if (b8.out_valid !== 4'b0100) begin mismatched++; $display("FAIL zero_ov got=%b want=0100", b8.out_valid); end
    if (b8.i2 !== 8'h00) begin mismatched++; $display("FAIL zero_i2 got=%h want=00", b8.i2); end
    if (act8() !== e8) begin mismatched++; $display("FAIL zero_w8 got=%h want=%h", act8(), e8); end
  endtask
  task automatic test_wide();
    logic [7:0] want_i1;
`ifdef DMUX4_REG_HOLD_EN
    want_i1 = 8'hA5;
`else
    want_i1 = 8'h00;
`endif
    drive(1'b1, 2'd1, 8'hA5);
    compared += 2;
    if (b8.i1 !== 8'hA5) begin mismatched++; $display("FAIL wide_i1 got=%h want=a5", b8.i1); end
    if (act8() !== e8) begin mismatched++; $display("FAIL wide_a5 got=%h want=%h", act8(), e8); end
    drive(1'b1, 2'd3, 8'h3C);
    compared += 3;
    if (b8.i3 !== 8'h3C) begin mismatched++; $display("FAIL wide_i3 got=%h want=3c", b8.i3); end
    if (b8.i1 !== want_i1) begin mismatched++; $display("FAIL wide_i1_after got=%h want=%h", b8.i1, want_i1); end
    if (act8() !== e8) begin mismatched++; $display("FAIL wide_3c got=%h want=%h", act8(), e8); end
  endtask
  task automatic test_reset_mid();
    drive(1'b1, 2'd2, 8'h5A);
    compared++;
    if (act8() !== e8) begin mismatched++; $display("FAIL mid_pre got=%h want=%h", act8(), e8); end
    @(negedge clk);
    set_in(1'b1, 2'd3, 8'hC3);
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if (act8() !== '0) begin mismatched++; $display("FAIL mid_async got=%h want=0", act8()); end
    @(posedge clk);
    #1;
    compared++;
    if (act8() !== '0) begin mismatched++; $display("FAIL mid_discard got=%h want=0", act8()); end
    m1 = '0;
    m8 = '0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 2'd3, 8'hC3);
    compared++;
    if (act8() !== '0) begin mismatched++; $display("FAIL mid_residual got=%h want=0", act8()); end
    drive(1'b1, 2'd0, 8'h81);
    compared += 2;
    if (act8() !== e8) begin mismatched++; $display("FAIL mid_post_w8 got=%h want=%h", act8(), e8); end
    if (act1() !== e1) begin mismatched++; $display("FAIL mid_post_w1 got=%h want=%h", act1(), e1); end
  endtask
  task automatic test_back_to_back();
    for (int n = 0; n < 60; n++) begin
      drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 8'($urandom));
      compared += 2;
      if (act1() !== e1) begin mismatched++; $display("FAIL b2b_w1 n=%0d got=%h want=%h", n, act1(), e1); end
      if (act8() !== e8) begin mismatched++; $display("FAIL b2b_w8 n=%0d got=%h want=%h", n, act8(), e8); end
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    set_in(1'b0, 2'd0, 8'h00);
    test_reset();
    test_sweep();
    test_idle();
    test_zero();
    test_wide();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
